// File: rtl/mac_col_mk_pkg.sv
// Shared constants and types for the multi-key systolic MAC column.
package mac_col_mk_pkg;
  localparam int INST_LOAD_BIT = 0;
  localparam int INST_EXEC_BIT = 1;

  typedef logic [1:0] inst_t;

  // Key-select width for a bank of n slots; never narrower than one bit.
  function automatic int ksel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KSEL_W = ksel_w(2);
endpackage

// File: rtl/mac_col_mk_dot_pipe.sv
// Signed pr-lane dot product, MAC_LAT register stages, valid shifted alongside.
// MAC_COL_RELU_EN: clamp negative sums to zero in the final register.
module mac_dot_pipe #(
  parameter int bw      = 8,
  parameter int pr      = 8,
  parameter int bw_psum = 2*bw+6,
  parameter int MAC_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vld_i,
  input  logic [pr*bw-1:0]          a_i,
  input  logic [pr*bw-1:0]          b_i,
  output logic                      vld_o,
  output logic signed [bw_psum-1:0] res_o
);
  localparam int SUM_W   = 2*bw + $clog2(pr) + 1;
  localparam int ACC_W   = (SUM_W > bw_psum) ? SUM_W : bw_psum;
  localparam int SUM_STG = (MAC_LAT == 1) ? 1 : 2;
  localparam int NDLY    = MAC_LAT - SUM_STG;

  logic [MAC_LAT:1] vld_q;
  logic [MAC_LAT:0] vld_pipe;
  assign vld_pipe = {vld_q, vld_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[MAC_LAT-1:0];
  end

  logic signed [2*bw-1:0] prod_c [pr];
  logic signed [2*bw-1:0] prod_s [pr];

  for (genvar l = 0; l < pr; l++) begin : g_lane
    assign prod_c[l] = (2*bw)'($signed(a_i[l*bw +: bw])) * (2*bw)'($signed(b_i[l*bw +: bw]));
  end

  // With one stage the whole MAC is combinational into the output register.
  if (MAC_LAT == 1) begin : g_noprod
    assign prod_s = prod_c;
  end else begin : g_prod
    logic signed [2*bw-1:0] prod_q [pr];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int l = 0; l < pr; l++) prod_q[l] <= '0;
      else if (vld_pipe[0]) prod_q <= prod_c;
    end
    assign prod_s = prod_q;
  end

  logic [ACC_W-1:0] sum_c;
  always_comb begin
    sum_c = '0;
    for (int l = 0; l < pr; l++)
      sum_c = sum_c + {{(ACC_W-2*bw){prod_s[l][2*bw-1]}}, prod_s[l]};
  end

  logic [ACC_W-1:0] fin_c;
  if (NDLY == 0) begin : g_nodly
    assign fin_c = sum_c;
  end else begin : g_dly
    logic [ACC_W-1:0] dly_q [NDLY];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < NDLY; i++) dly_q[i] <= '0;
      else begin
        dly_q[0] <= sum_c;
        for (int i = 1; i < NDLY; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign fin_c = dly_q[NDLY-1];
  end

  logic [ACC_W-1:0] fin_r;
  always_comb begin
    fin_r = fin_c;
`ifdef MAC_COL_RELU_EN
    if (fin_c[ACC_W-1]) fin_r = '0;
`endif
  end

  // Result register only loads on a valid beat so out holds between executes.
  logic [bw_psum-1:0] res_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     res_q <= '0;
    else if (vld_pipe[MAC_LAT-1])   res_q <= fin_r[bw_psum-1:0];
  end

  assign res_o = $signed(res_q);
  assign vld_o = vld_pipe[MAC_LAT];
endmodule

// File: rtl/mac_col_mk.sv
// Systolic MAC column with an NKEY-slot stationary key bank and pipelined dot product.
// MAC_COL_RELU_EN: when defined, out is clamped to zero for negative sums.
module mac_col_mk import mac_col_mk_pkg::*; #(
  parameter int bw      = 8,
  parameter int pr      = 8,
  parameter int bw_psum = 2*bw+6,
  parameter int col_id  = 0,
  parameter int NCOL    = 8,
  parameter int NKEY    = 2,
  parameter int MAC_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  inst_t                      i_inst,
  input  logic [pr*bw-1:0]           q_in,
  input  logic [ksel_w(NKEY)-1:0]    key_sel,
  output inst_t                      o_inst,
  output logic [pr*bw-1:0]           q_out,
  output logic signed [bw_psum-1:0]  out,
  output logic                       fifo_wr,
  output logic                       load_done
);
  localparam int KW    = ksel_w(NKEY);
  localparam int CNT_W = (NCOL > 1) ? $clog2(NCOL) : 1;

  inst_t                        inst_q;
  logic [KW-1:0]                sel_q, sel_mac_q, sel_eff;
  logic [pr*bw-1:0]             query_q, key_cur;
  logic                         exec_q, load_prev_q;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [KW-1:0]                slot_q, slot_d;
  logic                         done_q, done_d, key_we;
  logic [NKEY-1:0][pr*bw-1:0]   key_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q      <= '0;
      sel_q       <= '0;
      sel_mac_q   <= '0;
      query_q     <= '0;
      exec_q      <= 1'b0;
      load_prev_q <= 1'b0;
    end else begin
      inst_q      <= i_inst;
      sel_q       <= key_sel;
      exec_q      <= inst_q[INST_EXEC_BIT];
      load_prev_q <= inst_q[INST_LOAD_BIT];
      if (inst_q != '0) begin
        query_q   <= q_in;
        sel_mac_q <= sel_q;
      end
    end
  end

  // Load walks cnt over the columns once per slot; the falling edge of load re-arms.
  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    done_d = done_q;
    key_we = 1'b0;
    if (load_prev_q && !inst_q[INST_LOAD_BIT]) begin
      cnt_d  = '0;
      slot_d = '0;
      done_d = 1'b0;
    end else if (inst_q[INST_LOAD_BIT] && !done_q) begin
      key_we = (cnt_q == CNT_W'(col_id));
      if (cnt_q == CNT_W'(NCOL-1)) begin
        cnt_d = '0;
        if (slot_q == KW'(NKEY-1)) done_d = 1'b1;
        else                       slot_d = slot_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      slot_q <= '0;
      done_q <= 1'b0;
      key_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      done_q <= done_d;
      if (key_we) key_q[slot_q] <= q_in;
    end
  end

  assign sel_eff = (int'(sel_mac_q) < NKEY) ? sel_mac_q : '0;
  assign key_cur = key_q[sel_eff];

  mac_dot_pipe #(
    .bw(bw), .pr(pr), .bw_psum(bw_psum), .MAC_LAT(MAC_LAT)
  ) u_dot (
    .clk   (clk),
    .rst_n (reset),
    .vld_i (exec_q),
    .a_i   (query_q),
    .b_i   (key_cur),
    .vld_o (fifo_wr),
    .res_o (out)
  );

  assign o_inst    = inst_q;
  assign q_out     = query_q;
  assign load_done = done_q;
endmodule
